// File: rtl/mca_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined adder among N_REQ requesters, with tag-steered results.
// Optional per-requester grant / conflict counters are compiled in with `define MCA_ARB_STATS_EN.
package curve_params_pkg;
   localparam int FP_W = 280;
   typedef logic [FP_W-1:0] uint_fp_t;
endpackage

// Pipelined X+Y truncated to uint_fp_t; z reflects x/y sampled LATENCY clocks earlier.
module multi_cycle_adder
   import curve_params_pkg::*;
#(
   parameter int LATENCY = 3
) (
   input  logic     clk,
   input  uint_fp_t x,
   input  uint_fp_t y,
   output uint_fp_t z
);
   uint_fp_t pipe_q [LATENCY];

   always_ff @(posedge clk) begin
      pipe_q[0] <= x + y;
      for (int i = 1; i < LATENCY; i++) begin
         pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign z = pipe_q[LATENCY-1];
endmodule

// One grant per cycle, result LATENCY cycles after handshake; results cannot be stalled.
module mca_rr_arbiter
   import curve_params_pkg::*;
#(
   parameter  int N_REQ   = 4,
   parameter  int LATENCY = 3,
   localparam int IDX_W   = $clog2(N_REQ),
   localparam int CNT_W   = $clog2(LATENCY + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req_valid,
   output logic [N_REQ-1:0] req_ready,
   input  uint_fp_t         req_x [N_REQ],
   input  uint_fp_t         req_y [N_REQ],
   output logic [N_REQ-1:0] rsp_valid,
   output uint_fp_t         rsp_z,
   output logic [CNT_W-1:0] inflight,
   output logic             idle
`ifdef MCA_ARB_STATS_EN
   ,
   output logic [31:0]      stat_grants [N_REQ],
   output logic [31:0]      stat_conflict
`endif
);
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0] inflight_q, inflight_d;
   logic             grant_vld;
   logic [IDX_W-1:0] grant_idx;
   logic [IDX_W:0]   cand;
   uint_fp_t         add_x, add_y;
   logic [LATENCY-1:0] tag_vld_q;
   logic [IDX_W-1:0] tag_idx_q [LATENCY];
   logic             rsp_fire;

   // Descending scan so the lowest offset from rr_ptr is written last and wins.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
         if (cand >= (IDX_W+1)'(N_REQ)) begin
            cand = cand - (IDX_W+1)'(N_REQ);
         end
         if (!rst && req_valid[cand[IDX_W-1:0]]) begin
            grant_vld = 1'b1;
            grant_idx = cand[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (grant_vld) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant_vld) begin
         rr_ptr_d = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
      end
   end

   assign add_x = grant_vld ? req_x[grant_idx] : '0;
   assign add_y = grant_vld ? req_y[grant_idx] : '0;

   multi_cycle_adder #(
      .LATENCY(LATENCY)
   ) u_adder (
      .clk(clk),
      .x  (add_x),
      .y  (add_y),
      .z  (rsp_z)
   );

   assign rsp_fire = tag_vld_q[LATENCY-1] & ~rst;

   always_comb begin
      rsp_valid = '0;
      if (rsp_fire) begin
         rsp_valid[tag_idx_q[LATENCY-1]] = 1'b1;
      end
   end

   always_comb begin
      inflight_d = inflight_q;
      case ({grant_vld, rsp_fire})
         2'b10:   inflight_d = inflight_q + CNT_W'(1);
         2'b01:   inflight_d = inflight_q - CNT_W'(1);
         default: inflight_d = inflight_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q   <= '0;
         inflight_q <= '0;
         tag_vld_q  <= '0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         inflight_q   <= inflight_d;
         tag_vld_q[0] <= grant_vld;
         for (int i = 1; i < LATENCY; i++) begin
            tag_vld_q[i] <= tag_vld_q[i-1];
         end
      end
   end

   // Index stages only matter alongside their valid bit, so they are left unreset.
   always_ff @(posedge clk) begin
      tag_idx_q[0] <= grant_idx;
      for (int i = 1; i < LATENCY; i++) begin
         tag_idx_q[i] <= tag_idx_q[i-1];
      end
   end

   assign inflight = inflight_q;
   assign idle     = (inflight_q == '0) && !(|req_valid);

`ifdef MCA_ARB_STATS_EN
   logic [31:0] stat_grants_q [N_REQ];
   logic [31:0] stat_conflict_q;
   logic        conflict;

   // Clearing the lowest set bit leaves something only when two or more are set.
   assign conflict = |(req_valid & (req_valid - N_REQ'(1)));

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_REQ; i++) begin
            stat_grants_q[i] <= '0;
         end
         stat_conflict_q <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (req_ready[i] && (stat_grants_q[i] != '1)) begin
               stat_grants_q[i] <= stat_grants_q[i] + 32'd1;
            end
         end
         if (conflict && (stat_conflict_q != '1)) begin
            stat_conflict_q <= stat_conflict_q + 32'd1;
         end
      end
   end

   assign stat_grants   = stat_grants_q;
   assign stat_conflict = stat_conflict_q;
`endif
endmodule

// File: tb/tb_mca_rr_arbiter.sv
// Bench for mca_rr_arbiter: vector table, directed corner sequences and a random scoreboard run.
module tb_mca_rr_arbiter;
   import curve_params_pkg::*;

   localparam int N_REQ   = 4;
   localparam int LATENCY = 3;
   localparam int CNT_W   = $clog2(LATENCY + 1);
   localparam int N_VEC   = 25;

   typedef struct {
      int       idx;
      uint_fp_t z;
      int       due;
   } exp_t;

   typedef struct {
      logic             r;
      logic [N_REQ-1:0] vld;
      int               xb;
      int               yv;
      logic [N_REQ-1:0] rdy;
      logic [N_REQ-1:0] rsp;
      int               z;
      int               inf;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [N_REQ-1:0] req_valid;
   logic [N_REQ-1:0] req_ready;
   uint_fp_t         req_x [N_REQ];
   uint_fp_t         req_y [N_REQ];
   logic [N_REQ-1:0] rsp_valid;
   uint_fp_t         rsp_z;
   logic [CNT_W-1:0] inflight;
   logic             idle;
`ifdef MCA_ARB_STATS_EN
   logic [31:0]      stat_grants [N_REQ];
   logic [31:0]      stat_conflict;
`endif

   mca_rr_arbiter #(
      .N_REQ  (N_REQ),
      .LATENCY(LATENCY)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_x        (req_x),
      .req_y        (req_y),
      .rsp_valid    (rsp_valid),
      .rsp_z        (rsp_z),
      .inflight     (inflight),
`ifdef MCA_ARB_STATS_EN
      .idle         (idle),
      .stat_grants  (stat_grants),
      .stat_conflict(stat_conflict)
`else
      .idle         (idle)
`endif
   );

   always #5 clk = ~clk;

   int               total = 0;
   int               bad   = 0;
   int               cyc   = 0;
   int               m_ptr = 0;
   exp_t             sb [$];
   logic [N_REQ-1:0] s_rdy, s_rsp;
   uint_fp_t         s_z;
   logic [CNT_W-1:0] s_inf;
   logic             s_idle;
   vec_t             vt [N_VEC];

   task automatic chk(input string name, input uint_fp_t act, input uint_fp_t want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, want);
      end
   endtask

   function automatic uint_fp_t rnd_fp();
      uint_fp_t v = '0;
      for (int w = 0; w < 9; w++) begin
         v = (v << 32) | uint_fp_t'($urandom);
      end
      return v;
   endfunction

   task automatic drive(input logic r, input logic [N_REQ-1:0] vld, input int xb, input int yv);
      rst       = r;
      req_valid = vld;
      for (int i = 0; i < N_REQ; i++) begin
         req_x[i] = uint_fp_t'(xb + i);
         req_y[i] = uint_fp_t'(yv);
      end
   endtask

   // One clock: sample at negedge, compare against the model, then advance past the posedge.
   task automatic cycle();
      int               g;
      logic [N_REQ-1:0] want_rdy;
      logic [N_REQ-1:0] one;
      logic             want_idle;
      exp_t             e;
      @(negedge clk);
      s_rdy  = req_ready;
      s_rsp  = rsp_valid;
      s_z    = rsp_z;
      s_inf  = inflight;
      s_idle = idle;
      g = -1;
      if (!rst) begin
         for (int k = 0; k < N_REQ; k++) begin
            if (g < 0 && req_valid[(m_ptr + k) % N_REQ]) g = (m_ptr + k) % N_REQ;
         end
      end
      want_rdy = '0;
      if (g >= 0) want_rdy[g] = 1'b1;
      chk("req_ready", uint_fp_t'(s_rdy), uint_fp_t'(want_rdy));
      chk("inflight", uint_fp_t'(s_inf), uint_fp_t'(sb.size()));
      want_idle = (sb.size() == 0) && (req_valid == '0);
      chk("idle", uint_fp_t'(s_idle), uint_fp_t'(want_idle));
      if (!rst && sb.size() > 0 && sb[0].due == cyc) begin
         e   = sb.pop_front();
         one = '0;
         one[e.idx] = 1'b1;
         chk("rsp_valid", uint_fp_t'(s_rsp), uint_fp_t'(one));
         chk("rsp_z", s_z, e.z);
      end else begin
         chk("rsp_valid_idle", uint_fp_t'(s_rsp), '0);
      end
      if (g >= 0) begin
         e.idx = g;
         e.z   = req_x[g] + req_y[g];
         e.due = cyc + LATENCY;
         sb.push_back(e);
         m_ptr = (g == N_REQ - 1) ? 0 : g + 1;
      end
      if (rst) begin
         sb.delete();
         m_ptr = 0;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      uint_fp_t         big;
      logic [N_REQ-1:0] seen;

      // r, vld, xb, yv, exp ready, exp rsp one-hot, exp z, exp inflight
      vt[0]  = '{1'b0, 4'b0001,  5,   7, 4'b0001, 4'b0000,   0, 0};
      vt[1]  = '{1'b0, 4'b0000,  0,   0, 4'b0000, 4'b0000,   0, 1};
      vt[2]  = '{1'b0, 4'b0000,  0,   0, 4'b0000, 4'b0000,   0, 1};
      vt[3]  = '{1'b0, 4'b0000,  0,   0, 4'b0000, 4'b0001,  12, 1};
      vt[4]  = '{1'b0, 4'b0000,  0,   0, 4'b0000, 4'b0000,   0, 0};
      vt[5]  = '{1'b1, 4'b0000,  0,   0, 4'b0000, 4'b0000,   0, 0};
      vt[6]  = '{1'b0, 4'b1111,  0, 100, 4'b0001, 4'b0000,   0, 0};
      vt[7]  = '{1'b0, 4'b1111,  0, 100, 4'b0010, 4'b0000,   0, 1};
      vt[8]  = '{1'b0, 4'b1111,  0, 100, 4'b0100, 4'b0000,   0, 2};
      vt[9]  = '{1'b0, 4'b1111,  0, 100, 4'b1000, 4'b0001, 100, 3};
      vt[10] = '{1'b0, 4'b1111,  0, 100, 4'b0001, 4'b0010, 101, 3};
      vt[11] = '{1'b0, 4'b1111,  0, 100, 4'b0010, 4'b0100, 102, 3};
      vt[12] = '{1'b0, 4'b1111,  0, 100, 4'b0100, 4'b1000, 103, 3};
      vt[13] = '{1'b0, 4'b1111,  0, 100, 4'b1000, 4'b0001, 100, 3};
      vt[14] = '{1'b0, 4'b0000,  0,   0, 4'b0000, 4'b0010, 101, 3};
      vt[15] = '{1'b0, 4'b0000,  0,   0, 4'b0000, 4'b0100, 102, 2};
      vt[16] = '{1'b0, 4'b0000,  0,   0, 4'b0000, 4'b1000, 103, 1};
      vt[17] = '{1'b0, 4'b1000,  0,   1, 4'b1000, 4'b0000,   0, 0};
      vt[18] = '{1'b0, 4'b0010, 10,   1, 4'b0010, 4'b0000,   0, 1};
      vt[19] = '{1'b0, 4'b0001, 20,   2, 4'b0001, 4'b0000,   0, 2};
      vt[20] = '{1'b0, 4'b0011, 30,   3, 4'b0010, 4'b1000,   4, 3};
      vt[21] = '{1'b0, 4'b0000,  0,   0, 4'b0000, 4'b0010,  12, 3};
      vt[22] = '{1'b0, 4'b0000,  0,   0, 4'b0000, 4'b0001,  22, 2};
      vt[23] = '{1'b0, 4'b0000,  0,   0, 4'b0000, 4'b0010,  34, 1};
      vt[24] = '{1'b0, 4'b0000,  0,   0, 4'b0000, 4'b0000,   0, 0};

      drive(1'b1, '0, 0, 0);
      @(posedge clk);
      #1;

      // Reset state: grants stay low even with every request raised.
      drive(1'b1, 4'b1111, 0, 0);
      cycle();
      chk("rst_rdy", uint_fp_t'(s_rdy), '0);
      chk("rst_inflight", uint_fp_t'(s_inf), '0);

      for (int i = 0; i < N_VEC; i++) begin
         drive(vt[i].r, vt[i].vld, vt[i].xb, vt[i].yv);
         cycle();
         chk("tbl_rdy", uint_fp_t'(s_rdy), uint_fp_t'(vt[i].rdy));
         chk("tbl_rsp", uint_fp_t'(s_rsp), uint_fp_t'(vt[i].rsp));
         if (vt[i].rsp != '0) chk("tbl_z", s_z, uint_fp_t'(vt[i].z));
         chk("tbl_inf", uint_fp_t'(s_inf), uint_fp_t'(vt[i].inf));
      end

      // Truncation: (2^279+1)*2 wraps to 2 in 280 bits.
      big      = '0;
      big[279] = 1'b1;
      big[0]   = 1'b1;
      drive(1'b0, 4'b0001, 0, 0);
      req_x[0] = big;
      req_y[0] = big;
      cycle();
      chk("trunc_rdy", uint_fp_t'(s_rdy), uint_fp_t'(4'b0001));
      drive(1'b0, '0, 0, 0);
      cycle();
      cycle();
      cycle();
      chk("trunc_rsp", uint_fp_t'(s_rsp), uint_fp_t'(4'b0001));
      chk("trunc_z", s_z, uint_fp_t'(2));

      // Reset while three ops are in flight: none of them may ever respond.
      drive(1'b0, 4'b1111, 40, 9);
      cycle();
      cycle();
      cycle();
      drive(1'b1, '0, 0, 0);
      cycle();
      drive(1'b0, '0, 0, 0);
      cycle();
      chk("midrst_inf", uint_fp_t'(s_inf), '0);
      chk("midrst_idle", uint_fp_t'(s_idle), uint_fp_t'(1));
      seen = '0;
      for (int i = 0; i < LATENCY + 1; i++) begin
         cycle();
         seen |= s_rsp;
      end
      chk("midrst_drop", uint_fp_t'(seen), '0);
      drive(1'b0, 4'b1111, 0, 0);
      cycle();
      chk("midrst_first", uint_fp_t'(s_rdy), uint_fp_t'(4'b0001));

      for (int n = 0; n < 3000; n++) begin
         rst       = ($urandom_range(0, 299) == 0);
         req_valid = N_REQ'($urandom);
         for (int i = 0; i < N_REQ; i++) begin
            req_x[i] = rnd_fp();
            req_y[i] = rnd_fp();
         end
         cycle();
      end

      drive(1'b0, '0, 0, 0);
      for (int i = 0; i < LATENCY + 2; i++) cycle();
      chk("drain", uint_fp_t'(sb.size()), '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mca_rr_arbiter.md
Name: mca_rr_arbiter

Overview:
- Shares one multi_cycle_adder instance among N_REQ requesters, such as point-arithmetic units or Fp sequencers.
- Grants at most one add per cycle using round-robin arbitration.
- Tags every issued operation with its requester index through a LATENCY-deep tag pipeline aligned to the adder.
- Steers each sum back to its owner with a one-cycle one-hot valid strobe.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- LATENCY, 3, pipeline depth of the internal multi_cycle_adder (1..8). Passed to its latency parameter.
- IDX_W, $clog2(N_REQ), requester index width (derived localparam, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  N_REQ  requester i has an operation pending.
- req_ready  out  N_REQ  one-hot grant; handshake completes on req_valid[i] & req_ready[i].
- req_x  in  N_REQ x uint_fp_t  operand X per requester (CURVE_PARAMS type).
- req_y  in  N_REQ x uint_fp_t  operand Y per requester.
- rsp_valid  out  N_REQ  one-hot; sum for requester i is on rsp_z this cycle.
- rsp_z  out  uint_fp_t  shared result bus: X+Y truncated to uint_fp_t width, same as the adder.
- inflight  out  $clog2(LATENCY+1)  number of operations currently in the adder pipeline.
- idle  out  1  high when inflight==0 and no req_valid is asserted.

Behaviour:
- Single clock domain; reset is synchronous and active-high.
- Reset values:
  - rr_ptr=0, all tag-pipeline valid bits=0, inflight=0.
  - rsp_valid=0 and req_ready=0 during the rst cycle.
  - rsp_z is don't-care while rsp_valid=0.
- Arbitration (combinational):
  - Search req_valid starting at rr_ptr, ascending, wrapping modulo N_REQ.
  - The first set bit wins, and req_ready gets that single bit.
  - req_ready must never assert for a requester whose req_valid=0.
  - req_ready depends only on req_valid, rr_ptr and rst. No combinational path exists from req_x or req_y.
- Pointer update on a grant to index g: rr_ptr <= (g==N_REQ-1) ? 0 : g+1. With no grant, rr_ptr holds.
- Issue:
  - The winner's req_x and req_y are muxed to the adder X/Y in the same cycle.
  - With no grant, the adder inputs are driven to 0. The tag valid is 0, so the result is ignored.
- Tag pipeline:
  - Stage 0 is written at the grant edge with {valid=1, idx=g}. Stages then shift each clock.
  - Alignment to the adder: if grant is at edge T, rsp_valid[g]=1 with the correct rsp_z during the cycle after edge T+LATENCY-1 (LATENCY cycles after handshake). This matches the adder's Z timing.
- No result backpressure: requesters must accept rsp_valid whenever it asserts. Throughput is 1 op/cycle sustained.
- inflight counter:
  - +1 on grant, -1 on rsp_valid, net 0 when both happen in the same cycle.
  - Never exceeds LATENCY.
- Fairness: with all N_REQ continuously valid, grants cycle 0,1,...,N_REQ-1,0,... Each requester waits at most N_REQ-1 cycles.
- Simultaneous events:
  - A requester may issue a new request in the same cycle it receives rsp_valid.
  - A held request with unchanged operands counts as a new op each cycle it is granted; requesters deassert after the handshake.
- Reset mid-operation:
  - All tag valids are cleared; in-flight sums are dropped and never produce rsp_valid.
  - The adder datapath itself is not reset.
  - The first grant after rst deasserts starts the search from index 0.
- Boundary: with N_REQ not a power of two, rr_ptr wrap uses explicit compare, not bit truncation.

Optional Feature:
- Macro: MCA_ARB_STATS_EN.
- When defined:
  - Adds output stat_grants (N_REQ x 32), a per-requester saturating grant counter.
  - Adds output stat_conflict (32), which counts cycles where popcount(req_valid)>=2, saturating at 2^32-1.
  - Both counters clear on rst.
- When undefined: these ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Single requester, LATENCY=3: req_valid=0001, x=5, y=7 for one cycle -> req_ready=0001 that cycle; rsp_valid=0001 with rsp_z=12 exactly 3 cycles later; inflight goes 1,1,1,0.
- All four valid continuously for 8 cycles with x=i, y=100 -> grant order 0,1,2,3,0,1,2,3; rsp_z sequence 100,101,102,103,100,... with matching one-hot rsp_valid.
- Wrap and pointer hold: grant to 3, then only req 1 valid -> grant 1 and rr_ptr=2; next only req 0 valid -> grant 0.
- Truncation: x=y=2^279+1 (280-bit) -> rsp_z=2, matching adder truncation to uint_fp_t.
- Reset mid-flight: issue 3 ops on consecutive cycles, assert rst on the cycle after the third -> no rsp_valid ever for those ops; inflight=0 and idle=1 after rst.
- Random regression: 1e6 cycles of random req_valid and 280-bit operands, scoreboard per requester -> every handshake yields exactly one rsp_valid after LATENCY cycles with rsp_z = x+y; no req_ready without req_valid.
